// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared ASCII constants, baud divisor and line-buffer FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [7:0] c_ascii_bs       = 8'h08;
  localparam logic [7:0] c_ascii_lf       = 8'h0A;
  localparam logic [7:0] c_ascii_cr       = 8'h0D;
  localparam logic [7:0] c_ascii_del      = 8'h7F;
  localparam logic [7:0] c_ascii_print_lo = 8'h20;
  localparam logic [7:0] c_ascii_print_hi = 8'h7E;

  // 100 MHz system clock at 115200 baud.
  localparam int BAUD_DIV = 868;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REPLAY  = 2'd1,
    ST_EMIT_CR = 2'd2,
    ST_EMIT_LF = 2'd3
  } lb_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= c_ascii_print_lo) && (b <= c_ascii_print_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_buffer_if
// Description : RX strobe, TX handshake and status bundle for the line buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_line_buffer_if #(
  parameter int LW = 5
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] line_len;
  logic          busy;
  logic          overflow;
  logic          rx_lost;

  // The line buffer itself is the slave side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, line_len, busy, overflow, rx_lost
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, line_len, busy, overflow, rx_lost
  );
endinterface
`default_nettype wire

// File: rtl/uart_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_buffer
// Description : Collects an edited line from UART RX and replays it plus CR LF.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_line_buffer_if.slave     bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [LW-1:0] c_depth = LW'(DEPTH);

  lb_state_e     state_q;
  logic [LW-1:0] count_q;
  logic [LW-1:0] rd_idx_q;
  logic [LW-1:0] rd_idx_d;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic          overflow_q;
  logic          rx_lost_q;
  logic [7:0]    line_q [DEPTH];

  assign rd_idx_d = rd_idx_q + LW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      count_q     <= '0;
      rd_idx_q    <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      rx_lost_q   <= 1'b0;
    end else begin
      if (bus.in_valid && (state_q != ST_COLLECT)) begin
        rx_lost_q <= 1'b1;
      end

      case (state_q)
        ST_COLLECT: begin
          if (bus.in_valid) begin
            if (is_printable(bus.in_data)) begin
              if (count_q < c_depth) begin
                line_q[count_q[AW-1:0]] <= bus.in_data;
                count_q                 <= count_q + LW'(1);
              end else begin
                overflow_q <= 1'b1;
              end
            end else if ((bus.in_data == c_ascii_bs) || (bus.in_data == c_ascii_del)) begin
              if (count_q != '0) begin
                count_q <= count_q - LW'(1);
              end
            end else if (bus.in_data == c_ascii_cr) begin
              // First output byte is loaded here so it is valid the very next cycle.
              out_valid_q <= 1'b1;
              rd_idx_q    <= '0;
              if (count_q == '0) begin
                state_q    <= ST_EMIT_CR;
                out_data_q <= c_ascii_cr;
              end else begin
                state_q    <= ST_REPLAY;
                out_data_q <= line_q[0];
              end
            end
          end
        end

        ST_REPLAY: begin
          if (bus.out_ready) begin
            if (rd_idx_q == count_q - LW'(1)) begin
              state_q    <= ST_EMIT_CR;
              out_data_q <= c_ascii_cr;
            end else begin
              rd_idx_q   <= rd_idx_d;
              out_data_q <= line_q[rd_idx_d[AW-1:0]];
            end
          end
        end

        ST_EMIT_CR: begin
          if (bus.out_ready) begin
            state_q    <= ST_EMIT_LF;
            out_data_q <= c_ascii_lf;
          end
        end

        ST_EMIT_LF: begin
          if (bus.out_ready) begin
            state_q     <= ST_COLLECT;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            rd_idx_q    <= '0;
            overflow_q  <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_COLLECT;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.line_len  = count_q;
  assign bus.busy      = (state_q != ST_COLLECT);
  assign bus.overflow  = overflow_q;
  assign bus.rx_lost   = rx_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_line_buffer
// Description : Self-checking bench for uart_line_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_line_buffer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: the edited line as a queue plus the sticky flags.
  logic [7:0] line_m[$];
  bit         ovf_m;
  bit         lost_m;

  always #5 clk = ~clk;

  uart_line_buffer_if #(.LW(LW)) bus ();

  uart_line_buffer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (line_m.size() < DEPTH) line_m.push_back(b);
      else ovf_m = 1'b1;
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (line_m.size() > 0) void'(line_m.pop_back());
    end
    send_byte(b);
  endtask

  // Drains one line (model line + CR LF); caller sits on the negedge after the CR.
  task automatic collect_line(input string name, input bit rand_ready);
    logic [7:0] exp_q[$];
    logic [7:0] held;
    bit         stalled = 1'b0;
    bit         rdy;
    int         k = 0;
    int         cyc = 0;
    int         len = line_m.size();
    exp_q = line_m;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    while (k < exp_q.size() && cyc < 4000) begin
      cyc++;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s out_valid/busy byte %0d: got %b/%b expected 1/1", name, k, bus.out_valid, bus.busy);
      end
      if (stalled) begin
        checks++;
        if (bus.out_data !== held) begin
          failures++;
          $display("FAIL %s stall hold: got %h expected %h", name, bus.out_data, held);
        end
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      if (rdy) begin
        checks++;
        if (bus.out_data !== exp_q[k] || bus.line_len !== LW'(len)) begin
          failures++;
          $display("FAIL %s byte %0d: got data %h len %0d expected data %h len %0d",
                   name, k, bus.out_data, bus.line_len, exp_q[k], len);
        end
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = bus.out_data;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    if (k < exp_q.size()) begin
      failures++;
      $display("FAIL %s timeout: got %0d bytes expected %0d", name, k, exp_q.size());
    end
    line_m.delete();
    ovf_m = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.line_len !== '0 ||
        bus.overflow !== 1'b0 || bus.rx_lost !== lost_m) begin
      failures++;
      $display("FAIL %s idle after LF: got v=%b busy=%b len=%0d ovf=%b lost=%b expected 0 0 0 0 %b",
               name, bus.out_valid, bus.busy, bus.line_len, bus.overflow, bus.rx_lost, lost_m);
    end
  endtask

  task automatic test_reset();
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    line_m.delete();
    ovf_m  = 1'b0;
    lost_m = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.line_len !== '0 ||
        bus.overflow !== 1'b0 || bus.rx_lost !== 1'b0 || bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset: got v=%b busy=%b len=%0d ovf=%b lost=%b data=%h expected all zero",
               bus.out_valid, bus.busy, bus.line_len, bus.overflow, bus.rx_lost, bus.out_data);
    end
  endtask

  task automatic test_basic_ab();
    send_char(8'h41);
    send_char(8'h42);
    send_byte(8'h0D);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin
      failures++;
      $display("FAIL cr_latency: got v=%b data=%h expected 1 41", bus.out_valid, bus.out_data);
    end
    collect_line("basic_ab", 1'b0);
  endtask

  task automatic test_backspace();
    send_char(8'h41); send_char(8'h42); send_char(8'h43);
    send_char(8'h08);
    send_char(8'h44);
    send_byte(8'h0D);
    collect_line("backspace", 1'b0);
  endtask

  task automatic test_bs_empty();
    send_char(8'h08);
    send_char(8'h7F);
    checks++;
    if (bus.line_len !== '0) begin
      failures++;
      $display("FAIL bs_empty len: got %0d expected 0", bus.line_len);
    end
    send_byte(8'h0D);
    collect_line("bs_empty", 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) send_char(8'h61 + 8'(i));
    checks++;
    if (bus.overflow !== 1'b1 || bus.line_len !== LW'(DEPTH)) begin
      failures++;
      $display("FAIL overflow flag: got ovf=%b len=%0d expected 1 %0d", bus.overflow, bus.line_len, DEPTH);
    end
    send_byte(8'h0D);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow in replay: got %b expected 1", bus.overflow);
    end
    collect_line("overflow", 1'b1);
  endtask

  task automatic test_stall();
    send_char(8'h58);
    send_char(8'h59);
    send_byte(8'h0D);
    for (int i = 0; i < 50; i++) begin
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h58 || bus.line_len !== LW'(2)) begin
        failures++;
        $display("FAIL stall cycle %0d: got v=%b data=%h len=%0d expected 1 58 2",
                 i, bus.out_valid, bus.out_data, bus.line_len);
      end
      bus.in_valid = (i == 10);
      bus.in_data  = 8'h5A;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    lost_m = 1'b1;
    checks++;
    if (bus.rx_lost !== 1'b1) begin
      failures++;
      $display("FAIL stall rx_lost: got %b expected 1", bus.rx_lost);
    end
    collect_line("stall", 1'b0);
  endtask

  task automatic test_reset_mid_replay();
    send_char(8'h50);
    send_char(8'h51);
    send_byte(8'h0D);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    line_m.delete();
    ovf_m  = 1'b0;
    lost_m = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.line_len !== '0 || bus.rx_lost !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_replay: got v=%b busy=%b len=%0d lost=%b expected 0 0 0 0",
               bus.out_valid, bus.busy, bus.line_len, bus.rx_lost);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int ln = 0; ln < 30; ln++) begin
      for (int j = 0; j < int'($urandom_range(0, 22)); j++) begin
        case ($urandom_range(0, 9))
          6:       b = 8'h08;
          7:       b = 8'h7F;
          8:       b = 8'h0A;
          9: begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h0D) b = 8'h0A;
          end
          default: b = 8'($urandom_range(32, 126));
        endcase
        send_char(b);
      end
      checks++;
      if (bus.line_len !== LW'(line_m.size()) || bus.overflow !== ovf_m) begin
        failures++;
        $display("FAIL random line %0d pre-CR: got len=%0d ovf=%b expected len=%0d ovf=%b",
                 ln, bus.line_len, bus.overflow, line_m.size(), ovf_m);
      end
      send_byte(8'h0D);
      collect_line("random", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_ab();
    test_backspace();
    test_bs_empty();
    test_overflow();
    test_stall();
    test_reset_mid_replay();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_line_buffer.md
UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the line capacity in characters (power of two, >= 2).
REQ-002 The block SHALL have parameter LW, default $clog2(DEPTH)+1, giving the width of the length/index counters.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all logic is on posedge clk.
REQ-004 The block SHALL have port rst  input  1  the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port in_data  input  8  the received byte from the UART RX stage.
REQ-006 The block SHALL have port in_valid  input  1  a one-cycle strobe qualifying in_data, with no backpressure.
REQ-007 The block SHALL have port out_data  output  8  the byte offered to the UART TX stage.
REQ-008 The block SHALL have port out_valid  output  1  asserted when out_data is valid.
REQ-009 The block SHALL have port out_ready  input  1  asserted by TX when it is idle; a byte transfers on out_valid && out_ready.
REQ-010 The block SHALL have port line_len  output  LW  the number of characters currently buffered.
REQ-011 The block SHALL have port busy  output  1  high in every state except COLLECT.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: a printable character was dropped because the line was full.
REQ-013 The block SHALL have port rx_lost  output  1  sticky flag: a byte arrived while busy.

Function
REQ-014 The FSM SHALL have exactly the states COLLECT, REPLAY, EMIT_CR and EMIT_LF.
REQ-015 In COLLECT, in_valid with a printable byte (0x20-0x7E) SHALL be stored in buf[count], and count SHALL increment, if count < DEPTH.
REQ-016 In COLLECT, a printable byte received with count == DEPTH SHALL be dropped, overflow SHALL be set, and count SHALL remain unchanged.
REQ-017 In COLLECT, BS (0x08) or DEL (0x7F) SHALL decrement count if count > 0 and SHALL be ignored when count == 0; it never underflows.
REQ-018 In COLLECT, CR (0x0D) SHALL move the FSM to REPLAY with rd_idx = 0, or directly to EMIT_CR if count == 0.
REQ-019 In COLLECT, LF (0x0A) and all other bytes SHALL be ignored.
REQ-020 A CR accepted in cycle N SHALL produce out_valid = 1 in cycle N+1.
REQ-021 In REPLAY: out_valid = 1, out_data = buf[rd_idx]; on each transfer rd_idx increments; the transfer with rd_idx == count-1 moves the FSM to EMIT_CR.
REQ-022 In EMIT_CR: out_valid = 1, out_data = 0x0D; a transfer moves the FSM to EMIT_LF.
REQ-023 In EMIT_LF: out_valid = 1, out_data = 0x0A; a transfer returns the FSM to COLLECT, clears count to 0, and clears overflow.
REQ-024 out_data and out_valid SHALL be held stable while out_valid && !out_ready; stalls of unbounded length SHALL be legal.
REQ-025 out_valid SHALL be 0 in COLLECT.
REQ-026 in_valid while busy SHALL drop the byte and set rx_lost; buffer contents and count SHALL be untouched.
REQ-027 rx_lost SHALL be cleared only by rst.
REQ-028 line_len SHALL equal count in every state; it holds the full line length during REPLAY and EMIT_CR/EMIT_LF.
REQ-029 count SHALL saturate at DEPTH.
REQ-030 rd_idx SHALL never address beyond count-1.

Reset
REQ-031 rst SHALL take priority over all other inputs in the same cycle.
REQ-032 rst SHALL set state = COLLECT, count = 0, rd_idx = 0, overflow = 0 and rx_lost = 0, giving out_valid = 0, busy = 0 and line_len = 0.
REQ-033 out_data SHALL be 0x00 after reset.
REQ-034 Buffer contents SHALL need no reset.
REQ-035 rst asserted mid-REPLAY SHALL abort the line immediately; no further bytes are offered.

Structure
REQ-036 Shared package uart_pkg SHALL hold the ASCII constants (CR, LF, BS, DEL, printable range bounds) and BAUD_DIV.
REQ-037 The FSM state enum SHALL be a typedef in uart_pkg.
REQ-038 The block SHALL have no sub-module; the buffer is an inline register array with a synchronous write port.
REQ-039 The block SHALL sit between the UART RX byte strobe and the UART TX serializer at the top level.

Verification
REQ-040 Bench SHALL send "AB", then CR, with out_ready = 1 -> out stream 0x41, 0x42, 0x0D, 0x0A; line_len = 2 during replay, then 0; busy low afterwards.
REQ-041 Bench SHALL send "ABC", BS, "D", CR -> out stream 0x41, 0x42, 0x44, 0x0D, 0x0A.
REQ-042 Bench SHALL send BS at count 0, then CR -> no underflow; out stream is 0x0D, 0x0A only.
REQ-043 Bench SHALL send 17 printable bytes with DEPTH = 16, then CR -> overflow = 1, the first 16 bytes are replayed, and overflow = 0 after the LF transfer.
REQ-044 Bench SHALL send "XY", CR, hold out_ready = 0 for 50 cycles, strobe 'Z' during the stall, then release -> out_data stays 0x58 throughout the stall, rx_lost = 1, and the stream is 0x58, 0x59, 0x0D, 0x0A with no 'Z'.
REQ-045 Bench SHALL assert rst after the first REPLAY transfer -> next cycle out_valid = 0, busy = 0, line_len = 0 and rx_lost = 0.
